// File: rtl/mdma_pkg.sv
// Shared types and helpers for the multi-channel DMA completion/interrupt coalescing logic.
package mdma_pkg;

  localparam int unsigned CntwDef = 8;
  localparam int unsigned TmowDef = 16;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StFire
  } cplc_st_e;

  function automatic logic [31:0] popcount(input logic [63:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/mdma_cplc_chnl.sv
// Per-channel sticky completion flag and saturating completion counter.
module mdma_cplc_chnl
  import mdma_pkg::*;
#(
  parameter int unsigned CNTW = CntwDef
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            done_i,
  input  logic            clr_i,
  output logic            flag_o,
  output logic [CNTW-1:0] cnt_o
);

  logic            flag_q, flag_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // A completion coinciding with a clear wins: flag stays set, count restarts at one.
  always_comb begin
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (done_i) begin
      flag_d = 1'b1;
      if (clr_i) begin
        cnt_d = CNTW'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end else if (clr_i) begin
      flag_d = 1'b0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign flag_o = flag_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/mdma_cplc.sv
// Completion status, error capture and coalesced interrupt generation downstream of the DMA core.
module mdma_cplc
  import mdma_pkg::*;
#(
  parameter int unsigned CHNLC = 8,
  parameter int unsigned CNTW  = CntwDef,
  parameter int unsigned TMOW  = TmowDef
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [CHNLC-1:0]      dma_done,
  input  logic [CHNLC-1:0]      dma_active,
  input  logic                  dma_err,
  input  logic [CHNLC-1:0]      cfg_ie,
  input  logic                  cfg_eie,
  input  logic [CNTW-1:0]       cfg_thresh,
  input  logic [TMOW-1:0]       cfg_tmo,
  input  logic [CHNLC-1:0]      clr_done,
  input  logic                  clr_err,
  input  logic                  irq_ack,
  output logic [CHNLC-1:0]      done_flag,
  output logic [CHNLC*CNTW-1:0] done_cnt,
  output logic                  err_flag,
  output logic [CHNLC-1:0]      err_chnl,
  output logic [3:0]            err_cnt,
  output logic [CNTW-1:0]       pend,
  output logic                  irq,
  output logic                  irq_err
);

  for (genvar i = 0; i < CHNLC; i++) begin : g_chnl
    mdma_cplc_chnl #(
      .CNTW(CNTW)
    ) u_chnl (
      .clk_i (clk),
      .rst_ni(resetn),
      .done_i(dma_done[i]),
      .clr_i (clr_done[i]),
      .flag_o(done_flag[i]),
      .cnt_o (done_cnt[i*CNTW +: CNTW])
    );
  end

  // Error capture
  logic             dma_err_q;
  logic             err_edge;
  logic             err_flag_q, err_flag_d;
  logic [CHNLC-1:0] err_chnl_q, err_chnl_d;
  logic [3:0]       err_cnt_q, err_cnt_d;
  logic             irq_err_q;

  assign err_edge = dma_err & ~dma_err_q;

  // An error edge beats a simultaneous clear, so the clear acts as a restart of the capture.
  always_comb begin
    err_flag_d = err_flag_q;
    err_chnl_d = err_chnl_q;
    err_cnt_d  = err_cnt_q;
    if (err_edge) begin
      err_flag_d = 1'b1;
      if (!err_flag_q || clr_err) begin
        err_chnl_d = dma_active;
      end
      if (clr_err) begin
        err_cnt_d = 4'd1;
      end else if (err_cnt_q != 4'hF) begin
        err_cnt_d = err_cnt_q + 4'd1;
      end
    end else if (clr_err) begin
      err_flag_d = 1'b0;
      err_chnl_d = '0;
      err_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dma_err_q  <= 1'b0;
      err_flag_q <= 1'b0;
      err_chnl_q <= '0;
      err_cnt_q  <= '0;
      irq_err_q  <= 1'b0;
    end else begin
      dma_err_q  <= dma_err;
      err_flag_q <= err_flag_d;
      err_chnl_q <= err_chnl_d;
      err_cnt_q  <= err_cnt_d;
      irq_err_q  <= err_flag_q & cfg_eie;
    end
  end

  // Pending counter and coalescing FSM
  logic [63:0]     ie_vec;
  logic [CNTW-1:0] inc;
  logic [CNTW:0]   pend_wide;
  logic [CNTW-1:0] pend_sum;
  logic            tmo_hit;

  cplc_st_e        st_q, st_d;
  logic [CNTW-1:0] pend_q, pend_d;
  logic [TMOW-1:0] tmr_q, tmr_d;

  assign ie_vec    = 64'(dma_done & cfg_ie);
  assign inc       = CNTW'(popcount(ie_vec));
  assign pend_wide = {1'b0, pend_q} + {1'b0, inc};
  assign pend_sum  = pend_wide[CNTW] ? '1 : pend_wide[CNTW-1:0];
  assign tmo_hit   = (cfg_tmo != '0) && (tmr_q == TMOW'(1));

  always_comb begin
    st_d   = st_q;
    pend_d = pend_q;
    tmr_d  = tmr_q;
    unique case (st_q)
      StIdle: begin
        if (inc != '0) begin
          pend_d = inc;
          tmr_d  = cfg_tmo;
          st_d   = StCollect;
        end
      end
      StCollect: begin
        pend_d = pend_sum;
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TMOW'(1);
        end
        if ((pend_q >= cfg_thresh) || tmo_hit) begin
          st_d = StFire;
        end
      end
      StFire: begin
        if (irq_ack) begin
          pend_d = inc;
          if (inc != '0) begin
            tmr_d = cfg_tmo;
            st_d  = StCollect;
          end else begin
            st_d = StIdle;
          end
        end else begin
          pend_d = pend_sum;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q   <= StIdle;
      pend_q <= '0;
      tmr_q  <= '0;
    end else begin
      st_q   <= st_d;
      pend_q <= pend_d;
      tmr_q  <= tmr_d;
    end
  end

  assign err_flag = err_flag_q;
  assign err_chnl = err_chnl_q;
  assign err_cnt  = err_cnt_q;
  assign pend     = pend_q;
  assign irq      = (st_q == StFire);
  assign irq_err  = irq_err_q;

endmodule

// File: tb/tb_mdma_cplc.sv
// Scoreboard bench for mdma_cplc: a spec-level model predicts each cycle, a monitor compares.
module tb_mdma_cplc;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  dma_done, dma_active, cfg_ie, clr_done;
  logic        dma_err, cfg_eie, clr_err, irq_ack;
  logic [7:0]  cfg_thresh;
  logic [15:0] cfg_tmo;
  logic [7:0]  done_flag, err_chnl, pend;
  logic [63:0] done_cnt;
  logic        err_flag, irq, irq_err;
  logic [3:0]  err_cnt;

  always #5 clk = ~clk;

  mdma_cplc dut (
    .clk       (clk),
    .resetn    (resetn),
    .dma_done  (dma_done),
    .dma_active(dma_active),
    .dma_err   (dma_err),
    .cfg_ie    (cfg_ie),
    .cfg_eie   (cfg_eie),
    .cfg_thresh(cfg_thresh),
    .cfg_tmo   (cfg_tmo),
    .clr_done  (clr_done),
    .clr_err   (clr_err),
    .irq_ack   (irq_ack),
    .done_flag (done_flag),
    .done_cnt  (done_cnt),
    .err_flag  (err_flag),
    .err_chnl  (err_chnl),
    .err_cnt   (err_cnt),
    .pend      (pend),
    .irq       (irq),
    .irq_err   (irq_err)
  );

  typedef struct {
    logic [7:0]  flag;
    logic [63:0] cnt;
    logic        ef;
    logic [7:0]  ec;
    logic [3:0]  en;
    logic [7:0]  pend;
    logic        irq;
    logic        irqe;
  } snap_t;

  snap_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state, plain integers
  int   m_cnt[8];
  logic [7:0] m_flag, m_chnl;
  int   m_ecnt, m_pend, m_tmr, m_phase;  // phase: 0 idle, 1 collecting, 2 interrupt raised
  logic m_eflag, m_eprev, m_irqe;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_flag = '0; m_chnl = '0; m_ecnt = 0; m_pend = 0; m_tmr = 0; m_phase = 0;
    m_eflag = 1'b0; m_eprev = 1'b0; m_irqe = 1'b0;
  endtask

  task automatic model_step();
    int  inc;
    bit  fire;
    inc = $countones(dma_done & cfg_ie);
    m_irqe = m_eflag && cfg_eie;
    for (int i = 0; i < 8; i++) begin
      if (dma_done[i]) begin
        m_flag[i] = 1'b1;
        m_cnt[i]  = clr_done[i] ? 1 : sat(m_cnt[i] + 1, 255);
      end else if (clr_done[i]) begin
        m_flag[i] = 1'b0;
        m_cnt[i]  = 0;
      end
    end
    if (dma_err && !m_eprev) begin
      if (clr_err || !m_eflag) m_chnl = dma_active;
      m_ecnt  = clr_err ? 1 : sat(m_ecnt + 1, 15);
      m_eflag = 1'b1;
    end else if (clr_err) begin
      m_eflag = 1'b0; m_chnl = '0; m_ecnt = 0;
    end
    m_eprev = dma_err;
    if (m_phase == 0) begin
      if (inc > 0) begin m_pend = inc; m_tmr = int'(cfg_tmo); m_phase = 1; end
    end else if (m_phase == 1) begin
      fire = (m_pend >= int'(cfg_thresh)) || (cfg_tmo != 0 && m_tmr == 1);
      m_pend = sat(m_pend + inc, 255);
      if (m_tmr > 0) m_tmr--;
      if (fire) m_phase = 2;
    end else begin
      if (irq_ack) begin
        m_pend = inc;
        if (inc > 0) begin m_phase = 1; m_tmr = int'(cfg_tmo); end
        else m_phase = 0;
      end else begin
        m_pend = sat(m_pend + inc, 255);
      end
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.flag = m_flag;
    for (int i = 0; i < 8; i++) s.cnt[i*8 +: 8] = 8'(m_cnt[i]);
    s.ef = m_eflag; s.ec = m_chnl; s.en = 4'(m_ecnt); s.pend = 8'(m_pend);
    s.irq = (m_phase == 2); s.irqe = m_irqe;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    sb.push_back(model_snap());
    #1;
    dma_done = '0; clr_done = '0; clr_err = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " done_flag"}, 64'(done_flag), 64'h0);
    chk({tag, " done_cnt"}, done_cnt, 64'h0);
    chk({tag, " err_cnt"}, 64'(err_cnt), 64'h0);
    chk({tag, " err_chnl"}, 64'(err_chnl), 64'h0);
    chk({tag, " pend"}, 64'(pend), 64'h0);
    chk({tag, " irq"}, 64'(irq), 64'h0);
    chk({tag, " irq_err"}, 64'(irq_err), 64'h0);
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic async_reset();
    #2 resetn = 1'b0;
    model_reset();
    sb.delete();
    #1 check_zero("async_reset");
    @(negedge clk);
    resetn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      snap_t e;
      e = sb.pop_front();
      chk("sb done_flag", 64'(done_flag), 64'(e.flag));
      chk("sb done_cnt", done_cnt, e.cnt);
      chk("sb err_flag", 64'(err_flag), 64'(e.ef));
      chk("sb err_chnl", 64'(err_chnl), 64'(e.ec));
      chk("sb err_cnt", 64'(err_cnt), 64'(e.en));
      chk("sb pend", 64'(pend), 64'(e.pend));
      chk("sb irq", 64'(irq), 64'(e.irq));
      chk("sb irq_err", 64'(irq_err), 64'(e.irqe));
    end
  end

  initial begin
    resetn = 1'b0;
    dma_done = '0; dma_active = '0; dma_err = 1'b0; cfg_ie = '0; cfg_eie = 1'b0;
    cfg_thresh = 8'd1; cfg_tmo = '0; clr_done = '0; clr_err = 1'b0; irq_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;

    // Single completion, no coalescing
    cfg_ie = 8'h08; cfg_thresh = 8'd1;
    dma_done = 8'h08; tick();
    chk("t1 irq_n1", 64'(irq), 64'h0);
    tick();
    chk("t1 irq_n2", 64'(irq), 64'h1);
    chk("t1 done_flag", 64'(done_flag), 64'h08);
    chk("t1 done_cnt3", 64'(done_cnt[31:24]), 64'h1);
    irq_ack = 1'b1; tick();
    chk("t1 ack irq", 64'(irq), 64'h0);
    chk("t1 ack pend", 64'(pend), 64'h0);

    // Threshold of four
    cfg_ie = 8'hFF; cfg_thresh = 8'd4; cfg_tmo = '0;
    dma_done = 8'h07; tick();
    ticks(10);
    chk("t2 pend3", 64'(pend), 64'h3);
    chk("t2 no irq", 64'(irq), 64'h0);
    dma_done = 8'h20; tick(); tick();
    chk("t2 irq", 64'(irq), 64'h1);
    chk("t2 pend4", 64'(pend), 64'h4);
    irq_ack = 1'b1; tick();

    // Timeout path
    cfg_thresh = 8'd16; cfg_tmo = 16'd20;
    dma_done = 8'h02; tick();
    ticks(19);
    chk("t3 pre-timeout irq", 64'(irq), 64'h0);
    tick();
    chk("t3 timeout irq", 64'(irq), 64'h1);
    chk("t3 pend", 64'(pend), 64'h1);
    irq_ack = 1'b1; tick();
    cfg_tmo = '0;

    // Saturation on a disabled channel, then clear coinciding with done
    cfg_ie = 8'h7F; cfg_thresh = 8'd1;
    for (int k = 0; k < 300; k++) begin dma_done = 8'h80; tick(); end
    chk("t4 cnt7 sat", 64'(done_cnt[63:56]), 64'hFF);
    chk("t4 pend disabled", 64'(pend), 64'h0);
    dma_done = 8'h80; clr_done = 8'h80; tick();
    chk("t4 cnt7 clr+done", 64'(done_cnt[63:56]), 64'h1);
    chk("t4 flag7", 64'(done_flag[7]), 64'h1);

    // Error capture
    cfg_eie = 1'b1; dma_active = 8'h24; dma_err = 1'b1;
    ticks(5);
    dma_err = 1'b0; ticks(2);
    dma_active = 8'h01; dma_err = 1'b1; tick();
    dma_err = 1'b0; ticks(2);
    chk("t5 err_cnt", 64'(err_cnt), 64'h2);
    chk("t5 err_chnl", 64'(err_chnl), 64'h24);
    chk("t5 irq_err", 64'(irq_err), 64'h1);
    clr_err = 1'b1; tick();
    chk("t5 clr flag", 64'(err_flag), 64'h0);
    chk("t5 clr cnt", 64'(err_cnt), 64'h0);
    chk("t5 clr chnl", 64'(err_chnl), 64'h0);
    dma_err = 1'b1; tick();
    dma_err = 1'b0; tick();
    dma_active = 8'h24; dma_err = 1'b1; clr_err = 1'b1; tick();
    chk("t5 edge+clr cnt", 64'(err_cnt), 64'h1);
    chk("t5 edge+clr chnl", 64'(err_chnl), 64'h24);
    dma_err = 1'b0; clr_err = 1'b1; tick();

    // Ack coinciding with a new completion
    cfg_ie = 8'hFF; cfg_thresh = 8'd2;
    dma_done = 8'h01; tick();
    dma_done = 8'h02; tick();
    tick(); tick();
    chk("t6 fire", 64'(irq), 64'h1);
    irq_ack = 1'b1; dma_done = 8'h04; tick();
    chk("t6 ack+done pend", 64'(pend), 64'h1);
    chk("t6 ack+done irq", 64'(irq), 64'h0);
    dma_done = 8'h08; tick(); tick();
    chk("t6 refire", 64'(irq), 64'h1);
    irq_ack = 1'b1; tick();

    // Randomized traffic with occasional reconfiguration and resets
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) begin
        cfg_ie     = 8'($urandom);
        cfg_eie    = 1'($urandom);
        cfg_thresh = 8'($urandom_range(0, 6));
        cfg_tmo    = 16'($urandom_range(0, 10));
      end
      if ($urandom_range(0, 2) == 0) dma_done = 8'($urandom);
      if ($urandom_range(0, 7) == 0) clr_done = 8'($urandom);
      if ($urandom_range(0, 15) == 0) clr_err = 1'b1;
      if ($urandom_range(0, 3) == 0) irq_ack = 1'b1;
      if ($urandom_range(0, 5) == 0) dma_err = ~dma_err;
      if ($urandom_range(0, 9) == 0) dma_active = 8'($urandom);
      tick();
      if (c == 700 || c == 1500) async_reset();
    end

    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdma_cplc.md
Name: mdma_cplc

Overview:
- Completion and interrupt coalescing stage directly downstream of the multi-channel DMA core.
- Consumes the per-channel dma_done pulses, the shared dma_err and the per-channel dma_active vector.
- Keeps sticky per-channel completion and error status, saturating completion counters, and a coalesced interrupt with a threshold and a timeout. This replaces the raw OR-of-done interrupt.
- Status and clear strobes connect to the local APB SFR bank (cr/sr/ar style registers); this block contains no bus logic.

Parameters:
- CHNLC, 8, number of DMA channels.
- CNTW, 8, width of per-channel completion counters and of the pending counter.
- TMOW, 16, width of the coalescing timeout counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- dma_done  in  CHNLC  per-channel completion pulses from the DMA core.
- dma_active  in  CHNLC  per-channel active indication from the DMA core.
- dma_err  in  1  DMA bus-error indication (level, may stay high several cycles).
- cfg_ie  in  CHNLC  per-channel completion interrupt enable.
- cfg_eie  in  1  error interrupt enable.
- cfg_thresh  in  CNTW  coalescing threshold (pending completions).
- cfg_tmo  in  TMOW  coalescing timeout in clk cycles; 0 disables the timeout.
- clr_done  in  CHNLC  write-1-clear pulses for done_flag and done_cnt.
- clr_err  in  1  clear pulse for err_flag, err_chnl and err_cnt.
- irq_ack  in  1  acknowledge pulse for the coalesced interrupt.
- done_flag  out  CHNLC  sticky per-channel completion flags.
- done_cnt  out  CHNLC*CNTW  per-channel saturating completion counts, packed.
- err_flag  out  1  sticky error flag.
- err_chnl  out  CHNLC  channels active at the first error since the last clear.
- err_cnt  out  4  saturating error-event count.
- pend  out  CNTW  enabled completions not yet acknowledged.
- irq  out  1  coalesced completion interrupt.
- irq_err  out  1  error interrupt.

Behaviour:
- Reset: all flags, counters, pend and err_chnl are 0; the FSM is IDLE; irq and irq_err are 0.
- done_flag[i]:
  - Set on the cycle after dma_done[i]=1.
  - clr_done[i] clears it.
  - Set and clear in the same cycle: set wins.
- done_cnt[i]:
  - Increments on dma_done[i] and saturates at 2^CNTW-1.
  - clr_done[i] zeroes it.
  - Simultaneous increment and clear gives 1.
- Error detection: a rising edge of dma_err is detected against a registered copy of dma_err. Each edge is one error event; a held level counts once.
- Error event handling:
  - err_flag is set.
  - err_cnt increments, saturating at 15.
  - err_chnl loads dma_active only if err_flag was 0 (first-error capture).
- clr_err:
  - Clears err_flag, err_chnl and err_cnt.
  - Simultaneous with an error edge: the error wins, err_cnt=1 and err_chnl is recaptured.
- irq_err = err_flag & cfg_eie, registered. It is never coalesced.
- Pending counter:
  - inc = popcount(dma_done & cfg_ie) in the current cycle, range 0..CHNLC.
  - pend saturates at 2^CNTW-1.
- Coalescing FSM states:
  - IDLE: pend==0; irq=0. If inc>0, pend<=inc, load tmr<=cfg_tmo, go to COLLECT.
  - COLLECT: pend+=inc; tmr decrements when nonzero. Go to FIRE when pend>=cfg_thresh, or when cfg_tmo!=0 and tmr reaches 1→0.
  - FIRE: irq=1 and pend keeps accumulating. On irq_ack, pend<=inc of the ack cycle. Go to COLLECT (tmr reloaded) if inc>0, otherwise IDLE.
- cfg_thresh of 0 or 1 means no coalescing: COLLECT exits to FIRE on its first cycle.
- cfg_tmo=0 with cfg_thresh>pend leaves the FSM in COLLECT indefinitely. This is legal and intended; software relies on the threshold alone.
- Latency with cfg_thresh=1: dma_done in cycle N gives pend=1 and COLLECT in N+1, FIRE in N+2, irq=1 in N+2.
- irq_ack outside FIRE is ignored.
- Disabled channels: cfg_ie[i]=0 still updates done_flag and done_cnt but never contributes to pend.
- Clearing cfg_ie does not retroactively reduce pend.
- Arithmetic: the popcount is CNTW wide; pend+inc is computed CNTW+1 wide, then clamped.
- Reset mid-operation (asynchronous) returns everything to reset values immediately. No partial state survives.

Decomposition:
- Shared package mdma_pkg holds:
  - FSM state enum cplc_st_e {IDLE, COLLECT, FIRE}.
  - CNTW and TMOW default constants.
  - A popcount function.
- One sub-module, mdma_cplc_chnl, is instantiated CHNLC times in a generate loop. It owns done_flag[i] and done_cnt[i] with set/clear priority and saturation.
- Error logic, pending counter and FSM stay in the top module.

Test Plan:
- Single done pulse on ch3 with cfg_ie=8'h08, cfg_thresh=1 → done_flag=8'h08, done_cnt[3]=1, irq rises exactly 2 cycles later. irq_ack → irq=0, pend=0, FSM IDLE.
- cfg_thresh=4, cfg_tmo=0, done pulses on ch0..ch2 in one cycle, then ch5 ten cycles later (cfg_ie=8'hFF) → pend 3 with no irq, then pend 4 and irq asserted.
- cfg_thresh=16, cfg_tmo=20, one done on ch1 → irq asserts once tmr expires (21–22 cycles after the done) with pend=1.
- 300 done pulses on ch7 → done_cnt[7]=255 (saturated). clr_done[7] coincident with a done → done_cnt[7]=1, done_flag[7]=1.
- dma_err held high 5 cycles while dma_active=8'h24, a second edge with dma_active=8'h01, cfg_eie=1 → err_cnt=2, err_chnl=8'h24, irq_err=1. clr_err → all zero.
- irq_ack in the same cycle as a done on ch2 (cfg_thresh=2) → pend=1, FSM COLLECT, irq=0. A second done → irq reasserts.
